// File: rtl/fetch_queue.sv
// Instruction queue between fetch and dispatch holding {pc, instr, predicted_outcome} entries.
// Latency: one cycle enqueue-to-head; zero cycles on an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
// Backpressure: enq_ready drops when all DEPTH entries are occupied; flush empties the queue.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [WORD_W-1:0]        enq_pc,
    input  logic [WORD_W-1:0]        enq_instr,
    input  logic                     enq_pred_taken,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [WORD_W-1:0]        deq_pc,
    output logic [WORD_W-1:0]        deq_instr,
    output logic                     deq_pred_taken,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WORD_W-1:0] pc_mem    [DEPTH];
    logic [WORD_W-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]  pred_mem;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;

    logic empty;
    logic byp;
    logic byp_take;
    logic wr;
    logic rd;

    assign empty = (cnt == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // An empty queue forwards the fetch bundle straight to dispatch.
    assign byp = empty & enq_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign byp_take = byp & deq_ready;

    assign enq_ready      = (cnt != FULL);
    assign deq_valid      = ~empty | byp;
    assign deq_pc         = byp ? enq_pc         : pc_mem[head];
    assign deq_instr      = byp ? enq_instr      : instr_mem[head];
    assign deq_pred_taken = byp ? enq_pred_taken : pred_mem[head];
    assign count          = cnt;

    // A bypassed entry consumed the same cycle never touches storage.
    assign wr = enq_valid & enq_ready & ~byp_take;
    assign rd = ~empty & deq_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            pred_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (wr) begin
                pc_mem[tail]    <= enq_pc;
                instr_mem[tail] <= enq_instr;
                pred_mem[tail]  <= enq_pred_taken;
                tail            <= tail + 1'b1;
            end
            if (rd) begin
                head <= head + 1'b1;
            end
            case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based scoreboard of expected dequeue entries.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ent_t;

    logic        CLK;
    logic        nRST;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic        enq_pred_taken;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_pred_taken;
    logic        deq_ready;
    logic [2:0]  count;

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];

    fetch_queue #(.DEPTH(DEPTH), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .enq_pred_taken(enq_pred_taken), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
        .deq_pred_taken(deq_pred_taken), .deq_ready(deq_ready), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus, checks outputs mid-cycle, then updates the scoreboard after the edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic dr, input logic fl);
        int   sz;
        logic exp_rdy;
        logic exp_vld;
        logic byp;
        logic efire;
        logic dfire;
        ent_t hd;
        ent_t ne;
        ne.pc    = pc;
        ne.instr = pc ^ 32'h00A00093;
        ne.pred  = pc[2];
        enq_valid      = v;
        enq_pc         = ne.pc;
        enq_instr      = ne.instr;
        enq_pred_taken = ne.pred;
        deq_ready      = dr;
        flush          = fl;
        #1;
        sz      = sb.size();
        exp_rdy = (sz != DEPTH);
        exp_vld = (sz != 0);
        byp     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (sz == 0 && v && !fl) begin
            exp_vld = 1'b1;
            byp     = 1'b1;
        end
`endif
        chk("enq_ready", {31'd0, enq_ready}, {31'd0, exp_rdy});
        chk("deq_valid", {31'd0, deq_valid}, {31'd0, exp_vld});
        chk("count", {29'd0, count}, sz);
        chk("count_le_depth", {31'd0, (count <= 3'(DEPTH))}, 32'd1);
        if (exp_vld) begin
            hd = byp ? ne : sb[0];
            chk("deq_pc", deq_pc, hd.pc);
            chk("deq_instr", deq_instr, hd.instr);
            chk("deq_pred", {31'd0, deq_pred_taken}, {31'd0, hd.pred});
        end
        efire = v && exp_rdy;
        dfire = exp_vld && dr;
        @(posedge CLK);
        #1;
        if (fl) begin
            sb.delete();
        end else if (!(byp && dr)) begin
            if (dfire) void'(sb.pop_front());
            if (efire) sb.push_back(ne);
        end
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_pc = '0;
        enq_instr = '0; enq_pred_taken = 1'b0; deq_ready = 1'b0;
        #12;
        chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_deq_pc", deq_pc, 32'd0);
        chk("rst_deq_instr", deq_instr, 32'd0);
        chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Single enqueue, then fill to full with a held-off fifth entry, then drain.
        cycle(1'b1, 32'h100, 1'b0, 1'b0);
        chk("first_instr", deq_instr, 32'h00A00093 ^ 32'h100);
        cycle(1'b1, 32'h104, 1'b0, 1'b0);
        cycle(1'b1, 32'h108, 1'b0, 1'b0);
        cycle(1'b1, 32'h10C, 1'b0, 1'b0);
        chk("full_count", {29'd0, count}, 32'd4);
        cycle(1'b1, 32'h110, 1'b0, 1'b0);
        cycle(1'b1, 32'h110, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Wrap-around: fill, drain two, refill two, drain all.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h110, 1'b0, 1'b0);
        cycle(1'b1, 32'h114, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Steady stream: one in, one out every cycle.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with three entries while enqueuing and dequeuing.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h280 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 1'b1, 1'b1);
        chk("post_flush_valid", {31'd0, deq_valid}, 32'd0);
        cycle(1'b1, 32'h400, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_flush_head", deq_pc, 32'h400);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle with two entries held.
        cycle(1'b1, 32'h440, 1'b0, 1'b0);
        cycle(1'b1, 32'h444, 1'b0, 1'b0);
        enq_valid = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("arst_deq_pc", deq_pc, 32'd0);
        chk("arst_enq_ready", {31'd0, enq_ready}, 32'd1);
        sb.delete();
        @(posedge CLK); #1;
        nRST = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

`ifdef FETCH_QUEUE_BYPASS_EN
        cycle(1'b1, 32'h500, 1'b1, 1'b0);
        chk("bypass_count", {29'd0, count}, 32'd0);
        cycle(1'b1, 32'h504, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
`endif
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between fetch/branch stage and dispatch.
- Buffers fetched {pc, instr, predicted_outcome} triples so fetch keeps running while dispatch stalls.
- Produces the dispatch_free/stall backpressure that fetch consumes.
- Drops all buffered instructions on a misprediction flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WORD_W, 32, width of pc and instr fields.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  discard all entries (misprediction or pipeline flush).
- enq_valid  input  1  fetch presents a valid instruction.
- enq_pc  input  WORD_W  PC of fetched instruction.
- enq_instr  input  WORD_W  fetched instruction word.
- enq_pred_taken  input  1  branch predictor outcome for this PC.
- enq_ready  output  1  queue can accept; drives fetch dispatch_free.
- deq_valid  output  1  head entry valid.
- deq_pc  output  WORD_W  head PC.
- deq_instr  output  WORD_W  head instruction.
- deq_pred_taken  output  1  head predicted outcome.
- deq_ready  input  1  dispatch consumes head this cycle.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: DEPTH-entry circular buffer; head/tail pointers $clog2(DEPTH) bits wide, wrap naturally from DEPTH-1 to 0; count register tracks occupancy.
- Reset (nRST low, async): head=0, tail=0, count=0, all storage cleared to 0. Consequently deq_valid=0, deq_pc=0, deq_instr=0, deq_pred_taken=0, enq_ready=1.
- Enqueue fire = enq_valid & enq_ready. Dequeue fire = deq_valid & deq_ready.
- enq_ready = (count != DEPTH). No write-through when full, even if dequeuing the same cycle.
- deq_valid = (count != 0). deq_* show the head entry combinationally from storage (first-word-fall-through).
- Latency: a write lands at the edge. The entry is visible on deq_* the cycle after the enqueue fire.
- Enqueue fire: storage[tail] <= enq_*; tail <= tail+1.
- Dequeue fire: head <= head+1.
- count updates as +1 (enqueue only), -1 (dequeue only), or unchanged (both or neither).
- Simultaneous enqueue and dequeue at count=1: head advances, the new entry becomes head next cycle, count stays 1.
- Flush (synchronous, highest priority): next edge sets head=tail=0 and count=0. Any same-cycle enqueue or dequeue is ignored. Storage contents are not cleared. deq_valid is 0 the cycle after the flush.
- deq_ready while deq_valid=0: no effect.
- Asserting enq_valid while enq_ready=0: no effect. Fetch must hold its data until enq_ready is 1.
- Reset asserted mid-operation: state returns immediately to reset values. In-flight entries are lost without any indication.
- No overflow or underflow is possible by construction. The bench asserts count <= DEPTH every cycle.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0 and enq_valid=1, deq_valid=1 combinationally and deq_* = enq_*. Zero-cycle latency.
  - If deq_ready is also 1, the entry is consumed directly: nothing is written and pointers and count are unchanged.
  - If deq_ready=0, the entry is written normally.
  - Flush suppresses the bypass (deq_valid=0 while flush=1).
- Not defined: one-cycle latency as described in Behaviour; no combinational path from enq_* to deq_*.

Test Plan:
- Reset, then enqueue pc=0x100, instr=0x00A00093, pred=0 with deq_ready=0 -> next cycle deq_valid=1, deq_pc=0x100, deq_instr=0x00A00093, count=1.
- Enqueue pcs 0x100,0x104,0x108,0x10C with deq_ready=0 -> count=4, enq_ready=0. A 5th enqueue (0x110) is held off. Then dequeue 4 -> order 0x100..0x10C, then deq_valid=0, enq_ready=1.
- Wrap-around: fill 4, dequeue 2, enqueue 0x110 and 0x114, drain -> dequeue order 0x108, 0x10C, 0x110, 0x114; head and tail each wrapped once.
- Steady stream, enq_valid=deq_ready=1 for 10 cycles starting at pc 0x200, step 4 -> count constant at 1 after the first cycle; deq_pc sequence 0x200..0x224 in order, no gaps.
- Flush with count=3 while simultaneously enqueuing 0x300 and dequeuing -> next cycle count=0, deq_valid=0. 0x300 is never delivered. The next enqueue 0x400 appears at head.
- Assert nRST low asynchronously mid-cycle with count=2 -> outputs go to reset values before the next CLK edge. With FETCH_QUEUE_BYPASS_EN, an empty queue plus enq pc=0x500 and deq_ready=1 gives deq_pc=0x500 in the same cycle and count stays 0.
